// File: rtl/digit_scan_if.sv
// Control and display bus between the input front end, digit_scan_ctrl
// and digit_gen.
// master: drives the write/mode/inc strobes and consumes the display outputs.
// slave : the scan controller.
// Strobe semantics: there is no valid/ready backpressure. i_wr_en, i_mode and
// i_inc are each sampled on every rising i_clk edge. A strobe held high for
// N cycles acts as N events. The controller is always ready, but it ignores
// strobes that have no meaning in the current FSM state.
interface digit_scan_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int AW = $clog2(NUM_DIGITS);

    logic                  i_wr_en;
    logic [AW-1:0]         i_wr_addr;
    logic [3:0]            i_wr_data;
    logic                  i_mode;
    logic                  i_inc;
    logic [3:0]            o_digit;
    logic                  o_blink;
    logic                  o_clk2Hz;
    logic [NUM_DIGITS-1:0] o_digit_sel;
    logic                  o_edit;
    logic [AW-1:0]         o_cursor;
    logic                  o_state;    // raw FSM state, for checkers

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_mode, i_inc,
        input  o_digit, o_blink, o_clk2Hz, o_digit_sel, o_edit, o_cursor, o_state
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_mode, i_inc,
        output o_digit, o_blink, o_clk2Hz, o_digit_sel, o_edit, o_cursor, o_state
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexes NUM_DIGITS hex digits onto one digit_gen.
// The block owns the digit register file, the scan and slot counters, the
// free-running blink square wave and the IDLE/EDIT cursor FSM.
// Optional feature: define DIGIT_SCAN_LZB_EN to enable leading-zero blanking.
// Blanking applies in IDLE only.
module digit_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 16,
    parameter int BLINK_DIV  = 2500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    digit_scan_if.slave bus
);
    localparam int AW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [AW-1:0]         LAST_SLOT  = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]           NUM_D      = (AW + 1)'(NUM_DIGITS);
    localparam logic [SW-1:0]         SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EDIT = 1'b1;

    logic [0:0]            state;
    logic [AW-1:0]         cursor;
    logic [3:0]            regs [NUM_DIGITS];
    logic [SW-1:0]         scan_cnt;
    logic [AW-1:0]         slot;
    logic [BW-1:0]         blink_cnt;
    logic                  clk2hz_q;
    logic [3:0]            digit_q;
    logic                  blink_q;
    logic [NUM_DIGITS-1:0] sel_q;

    logic                  scan_wrap;
    logic [AW-1:0]         slot_nxt;
    logic                  wr_ok;
    logic [NUM_DIGITS-1:0] slot_onehot;
    logic [NUM_DIGITS-1:0] keep;

    assign scan_wrap   = (scan_cnt == SCAN_LAST);
    assign slot_nxt    = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    assign wr_ok       = ({1'b0, bus.i_wr_addr} < NUM_D);
    assign slot_onehot = SEL_ONE << slot;

`ifdef DIGIT_SCAN_LZB_EN
    logic nz_above;

    // A slot stays enabled if it or any more-significant digit is nonzero.
    // Digit 0 and every digit in EDIT are always enabled.
    always_comb begin
        keep     = '0;
        nz_above = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nz_above = nz_above | (regs[k] != 4'd0);
            keep[k]  = nz_above || (k == 0) || (state == ST_EDIT);
        end
    end
`else
    assign keep = '1;
`endif

    // Scan counter: SCAN_DIV clocks per slot. The slot index wraps after the last digit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scan_cnt <= '0;
            slot     <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            slot     <= slot_nxt;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Display outputs: digit and blink load at slot start.
    // The anode enable stays dark for the first cycle of each slot.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            digit_q <= 4'd0;
            blink_q <= 1'b0;
            sel_q   <= '0;
        end else if (scan_wrap) begin
            digit_q <= regs[slot_nxt];
            blink_q <= (state == ST_EDIT) && (slot_nxt == cursor);
            sel_q   <= '0;
        end else if (scan_cnt == '0) begin
            sel_q   <= slot_onehot & keep;
        end
    end

    // Blink generator: free-running; toggles o_clk2Hz every BLINK_DIV clocks.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            blink_cnt <= '0;
            clk2hz_q  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            clk2hz_q  <= ~clk2hz_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Edit FSM: i_mode enters EDIT, steps the cursor, and leaves after the last digit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cursor <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_mode) begin
                        state  <= ST_EDIT;
                        cursor <= '0;
                    end
                end
                ST_EDIT: begin
                    if (bus.i_mode) begin
                        if (cursor == LAST_SLOT) begin
                            state  <= ST_IDLE;
                            cursor <= '0;
                        end else begin
                            cursor <= cursor + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cursor <= '0;
                end
            endcase
        end
    end

    // Register file: external writes happen only in IDLE.
    // In EDIT, i_inc adds 1 (mod 16) to the digit at the pre-advance cursor.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                regs[k] <= 4'd0;
            end
        end else if (state == ST_IDLE) begin
            if (bus.i_wr_en && wr_ok) begin
                regs[bus.i_wr_addr] <= bus.i_wr_data;
            end
        end else if (bus.i_inc) begin
            regs[cursor] <= regs[cursor] + 4'd1;
        end
    end

    assign bus.o_digit     = digit_q;
    assign bus.o_blink     = blink_q;
    assign bus.o_clk2Hz    = clk2hz_q;
    assign bus.o_digit_sel = sel_q;
    assign bus.o_edit      = (state == ST_EDIT);
    assign bus.o_cursor    = cursor;
    assign bus.o_state     = state;
endmodule
